// File: rtl/alu_seq_display.sv
// Sequential add/sub/mul/div ALU with double-dabble BCD and seven-segment output.
// Define ALU_SEQ_SEG_ACTIVE_LOW_EN for active-low segment drive.
module alu_seq_display #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  input  logic [1:0]           operation,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 neg,
  output logic                 div_err,
  output logic [2*WIDTH-1:0]   alu_result,
  output logic [7*DIGITS-1:0]  hex
);

  localparam int RW = 2 * WIDTH;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(RW + 1);

  localparam logic [CW-1:0] C_EX_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_CV_LAST = CW'(RW - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_CONV = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

`ifdef ALU_SEQ_SEG_ACTIVE_LOW_EN
  localparam bit SEG_INV = 1'b1;
`else
  localparam bit SEG_INV = 1'b0;
`endif

  localparam logic [6:0] SEG_BLANK = SEG_INV ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_ZERO  = SEG_INV ? 7'h40 : 7'h3F;
  localparam logic [7*DIGITS-1:0] HEX_RST =
    {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};

  function automatic int dec_digits(input int w);
    logic [63:0] v;
    int n;
    v = (64'd1 << (2 * w)) - 64'd1;
    n = 0;
    while (v != 64'd0) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("alu_seq_display: WIDTH out of range 2..16");
    end
    if (DIGITS < dec_digits(WIDTH)) begin : g_bad_digits
      $error("alu_seq_display: DIGITS too small for 2*WIDTH result");
    end
  endgenerate

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return SEG_INV ? ~p : p;
  endfunction

  logic [2:0]        r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [1:0]        r_op;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_acc;
  logic [RW-1:0]     r_mc;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_rem;
  logic [RW-1:0]     r_res;
  logic [RW-1:0]     r_bin;
  logic [BW-1:0]     r_bcd;
  logic              r_busy;
  logic              r_done;
  logic              r_neg;
  logic              r_err;
  logic [RW-1:0]     r_alu;
  logic [7*DIGITS-1:0] r_hex;

  logic [RW-1:0]     w_sum;
  logic              w_lt;
  logic [WIDTH-1:0]  w_diff;
  logic [RW-1:0]     w_acc_nx;
  logic [WIDTH:0]    w_sh;
  logic [WIDTH:0]    w_sub;
  logic              w_ge;
  logic [WIDTH-1:0]  w_rem_nx;
  logic [WIDTH-1:0]  w_q_nx;
  logic              w_last;
  logic              w_dz;
  logic [RW-1:0]     w_res_nx;
  logic              w_fin;
  logic [RW-1:0]     w_disp;
  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_bcd_nx;
  logic [7*DIGITS-1:0] w_hex;
  logic              w_nz;

  assign w_sum    = {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
  assign w_lt     = r_a < r_b;
  assign w_diff   = w_lt ? r_b - r_a : r_a - r_b;
  assign w_acc_nx = r_q[0] ? r_acc + r_mc : r_acc;
  // restoring step: sign of the trial subtract decides the quotient bit
  assign w_sh     = {r_rem, r_q[WIDTH-1]};
  assign w_sub    = w_sh - {1'b0, r_b};
  assign w_ge     = ~w_sub[WIDTH];
  assign w_rem_nx = w_ge ? w_sub[WIDTH-1:0] : w_sh[WIDTH-1:0];
  assign w_q_nx   = {r_q[WIDTH-2:0], w_ge};
  assign w_last   = r_cnt == C_EX_LAST;
  assign w_dz     = r_b == '0;

  always_comb begin
    w_res_nx = '0;
    w_fin    = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res_nx = w_sum;
        w_fin    = 1'b1;
      end
      OP_SUB: begin
        w_res_nx = {{WIDTH{1'b0}}, w_diff};
        w_fin    = 1'b1;
      end
      OP_MUL: begin
        w_res_nx = w_acc_nx;
        w_fin    = w_last;
      end
      default: begin
        w_res_nx = w_dz ? {r_a, {WIDTH{1'b1}}} : {w_rem_nx, w_q_nx};
        w_fin    = w_dz | w_last;
      end
    endcase
  end

  assign w_disp = (r_op == OP_DIV) ?
    {{WIDTH{1'b0}}, w_res_nx[WIDTH-1:0]} : w_res_nx;

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  assign w_bcd_nx = (w_adj << 1) | BW'(r_bin[RW-1]);

  // blank digits above the most significant nonzero one
  always_comb begin
    w_hex = {DIGITS{SEG_BLANK}};
    w_nz  = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (w_bcd_nx[4*k +: 4] != 4'd0)
        w_nz = 1'b1;
      if (w_nz || k == 0)
        w_hex[7*k +: 7] = f_seg(w_bcd_nx[4*k +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mc    <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_res   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
      r_alu   <= '0;
      r_hex   <= HEX_RST;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= num1;
            r_b     <= num2;
            r_op    <= operation;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_neg   <= 1'b0;
          r_err   <= 1'b0;
          r_cnt   <= '0;
          r_acc   <= '0;
          r_mc    <= {{WIDTH{1'b0}}, r_a};
          r_q     <= (r_op == OP_DIV) ? r_a : r_b;
          r_rem   <= '0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_op == OP_MUL) begin
            r_acc <= w_acc_nx;
            r_mc  <= r_mc << 1;
            r_q   <= r_q >> 1;
          end
          if (r_op == OP_DIV) begin
            r_rem <= w_rem_nx;
            r_q   <= w_q_nx;
          end
          if (r_op == OP_SUB)
            r_neg <= w_lt;
          if (r_op == OP_DIV && w_dz)
            r_err <= 1'b1;
          if (w_fin) begin
            r_res   <= w_res_nx;
            r_bin   <= w_disp;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_bin <= r_bin << 1;
          r_bcd <= w_bcd_nx;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == C_CV_LAST) begin
            r_alu   <= r_res;
            r_hex   <= w_hex;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign neg        = r_neg;
  assign div_err    = r_err;
  assign alu_result = r_alu;
  assign hex        = r_hex;

endmodule
